// File: rtl/tag_sched_pkg.sv
// Shared types and defaults for the tag frame scheduler: FSM state encoding,
// the tag marker byte and the default stream/tag/length widths.
package tag_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [7:0] TAG_MARKER = 8'h5a;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_TAG_W  = 256;
    localparam int DEF_LEN_W  = 16;
    localparam int OVF_W      = 16;

endpackage

// File: rtl/tag_pend_slot.sv
// One-deep pending tag register. A write always wins over the held tag; a write
// onto a full slot that is not being drained in the same cycle counts as an overflow.
module tag_pend_slot
    import tag_sched_pkg::*;
#(
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             full_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [OVF_W-1:0] ovf_cnt_o
);

    logic             full_q, full_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    always_comb begin
        full_d = wr_i | (full_q & ~rd_i);
        tag_d  = wr_i ? tag_i : tag_q;
        ovf_d  = ovf_q;
        if (wr_i && full_q && !rd_i && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            tag_q  <= '0;
            ovf_q  <= '0;
        end else begin
            full_q <= full_d;
            tag_q  <= tag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign full_o    = full_q;
    assign tag_o     = tag_q;
    assign ovf_cnt_o = ovf_q;

endmodule

// File: rtl/tag_frame_sched.sv
// Per-CPI frame scheduler: emits the tag as a header burst, then passes frame_len ADC
// beats through with tlast. Optional TAG_HDR_CHECK_EN rejects tags without the marker byte.
module tag_frame_sched
    import tag_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              tag_valid,
    input  logic [TAG_W-1:0]  tag_info,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              frame_done,
    output logic [OVF_W-1:0]  ovf_cnt
`ifdef TAG_HDR_CHECK_EN
    ,
    output logic              hdr_err
`endif
);

    localparam int HDR_BEATS = TAG_W / DATA_W;
    localparam int BEAT_W    = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              frame_done_q, frame_done_d;
`ifdef TAG_HDR_CHECK_EN
    logic              hdr_err_q, hdr_err_d;
`endif

    logic                              pend_full, pend_rd, pend_wr;
    logic [TAG_W-1:0]                  pend_tag, start_tag;
    logic                              start_req, tag_ok, last_hdr;
    logic [HDR_BEATS-1:0][DATA_W-1:0]  hdr_words;

    assign hdr_words = tag_q;

    // A queued tag always goes first; a live pulse starts directly only when the slot is empty.
    assign start_req = (state_q == ST_IDLE) && enable && (pend_full || tag_valid);
    assign start_tag = pend_full ? pend_tag : tag_info;
    assign pend_rd   = start_req && pend_full;
    assign pend_wr   = tag_valid && !(start_req && !pend_full);

`ifdef TAG_HDR_CHECK_EN
    assign tag_ok = (start_tag[TAG_W-1 -: 8] == TAG_MARKER);
`else
    assign tag_ok = 1'b1;
`endif

    assign last_hdr = (beat_q == BEAT_W'(HDR_BEATS - 1));

    tag_pend_slot #(
        .TAG_W (TAG_W)
    ) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (pend_wr),
        .rd_i      (pend_rd),
        .tag_i     (tag_info),
        .full_o    (pend_full),
        .tag_o     (pend_tag),
        .ovf_cnt_o (ovf_cnt)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        beat_d        = beat_q;
        frame_done_d  = 1'b0;
`ifdef TAG_HDR_CHECK_EN
        hdr_err_d     = 1'b0;
`endif
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (tag_ok) begin
                        state_d = ST_HDR;
                        tag_d   = start_tag;
                        len_d   = frame_len;
                        beat_d  = '0;
                    end else begin
`ifdef TAG_HDR_CHECK_EN
                        hdr_err_d = 1'b1;
`endif
                    end
                end
            end

            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_words[beat_q];
                m_axis_tlast  = last_hdr && (len_q == '0);
                if (m_axis_tready) begin
                    if (!last_hdr) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else if (len_q == '0) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
            end

            ST_DATA: begin
                // Pure pass-through; ready only reaches the ADC while this state holds.
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = (cnt_q == (len_q - LEN_W'(1)));
                if (s_axis_tvalid && m_axis_tready) begin
                    if (m_axis_tlast) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            frame_done_q <= 1'b0;
`ifdef TAG_HDR_CHECK_EN
            hdr_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            frame_done_q <= frame_done_d;
`ifdef TAG_HDR_CHECK_EN
            hdr_err_q    <= hdr_err_d;
`endif
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
`ifdef TAG_HDR_CHECK_EN
    assign hdr_err    = hdr_err_q;
`endif

endmodule

// File: tb/tb_tag_frame_sched.sv
// Self-checking bench for tag_frame_sched: expected DMA stream is built per frame from
// the tag words and an indexed ADC sample sequence; optional TAG_HDR_CHECK_EN is honoured.
module tb_tag_frame_sched;

    localparam int DATA_W    = 64;
    localparam int TAG_W     = 256;
    localparam int LEN_W     = 16;
    localparam int HDR_BEATS = TAG_W / DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              tag_valid;
    logic [TAG_W-1:0]  tag_info;
    logic [LEN_W-1:0]  frame_len;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              busy;
    logic              frame_done;
    logic [15:0]       ovf_cnt;
`ifdef TAG_HDR_CHECK_EN
    logic              hdr_err;
`endif

    always #5 clk = ~clk;

    tag_frame_sched #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .tag_valid     (tag_valid),
        .tag_info      (tag_info),
        .frame_len     (frame_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .frame_done    (frame_done),
        .ovf_cnt       (ovf_cnt)
`ifdef TAG_HDR_CHECK_EN
        ,
        .hdr_err       (hdr_err)
`endif
    );

    int    total = 0;
    int    bad   = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];

    int                src_idx     = 0;
    bit                src_took    = 1'b0;
    bit                src_rand    = 1'b0;
    int                rdy_mode    = 0;
    bit                rdy_tog     = 1'b0;
    int                cyc         = 0;
    int                done_cnt    = 0;
    int                srdy_cycles = 0;
    int                stall_viol  = 0;
    int                tlast_cyc   = -1;
    int                done_cyc    = -1;
    bit                prev_stall  = 1'b0;
    logic [DATA_W-1:0] prev_data   = '0;
    int                exp_src_idx = 0;
    int                ovf_exp     = 0;

    function automatic logic [DATA_W-1:0] sample_val(int idx);
        return {32'hADC0_0000 + 32'(idx), ~32'(idx)};
    endfunction

    function automatic logic [TAG_W-1:0] make_tag(logic [31:0] id, logic [7:0] marker);
        logic [TAG_W-1:0] t;
        for (int i = 0; i < TAG_W / 32; i++) t[i*32 +: 32] = $urandom();
        t[31:0]          = id;
        t[TAG_W-1 -: 8]  = marker;
        return t;
    endfunction

    // Expected DMA beats of one frame: tag words little-endian, then the next len ADC samples.
    task automatic expect_frame(logic [TAG_W-1:0] tag, int len);
        beat_t b;
        for (int k = 0; k < HDR_BEATS; k++) begin
            b.data = tag[k*DATA_W +: DATA_W];
            b.last = (len == 0) && (k == HDR_BEATS - 1);
            exp_q.push_back(b);
        end
        for (int j = 0; j < len; j++) begin
            b.data = sample_val(exp_src_idx);
            b.last = (j == len - 1);
            exp_src_idx++;
            exp_q.push_back(b);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_q.size() || i >= exp_q.size()) return i;
            if (obs_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic beat_t obs_at(int i);
        return (i < obs_q.size()) ? obs_q[i] : 'x;
    endfunction

    function automatic beat_t exp_at(int i);
        return (i < exp_q.size()) ? exp_q[i] : 'x;
    endfunction

    // One clock: drive source/sink for this cycle, observe the handshakes, advance past the edge.
    task automatic tick();
        if (src_took) src_idx++;
        if (!(s_axis_tvalid && !src_took)) s_axis_tvalid = !src_rand || ($urandom_range(0, 3) != 0);
        s_axis_tdata = sample_val(src_idx);
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       begin rdy_tog = !rdy_tog; m_axis_tready = rdy_tog; end
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        src_took = s_axis_tvalid && s_axis_tready;
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data)) stall_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tdata, m_axis_tlast});
            if (m_axis_tlast) tlast_cyc = cyc;
        end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (s_axis_tready) srdy_cycles++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_beats(int n, int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (obs_q.size() < n) begin
            bad++;
            $display("FAIL wait_beats: got %0d beats, required %0d within %0d cycles", obs_q.size(), n, budget);
        end
    endtask

    task automatic start_scenario();
        obs_q.delete();
        exp_q.delete();
        done_cnt    = 0;
        srdy_cycles = 0;
        stall_viol  = 0;
        tlast_cyc   = -1;
        done_cyc    = -1;
        exp_src_idx = src_idx + (src_took ? 1 : 0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, frame_done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got {tvalid,tlast,s_tready,busy,done}=%b required 00000",
                     {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, frame_done});
        end
        total++;
        if (m_axis_tdata !== '0) begin
            bad++; $display("FAIL reset_tdata: got %h required 0", m_axis_tdata);
        end
        total++;
        if (ovf_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_ovf: got %0d required 0", ovf_cnt);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        logic [TAG_W-1:0] t;
        int d;
        start_scenario();
        rdy_mode = 0; src_rand = 0;
        t = make_tag(32'h0000_0007, 8'h5a);
        expect_frame(t, 3);
        tag_valid = 1'b1; tag_info = t; frame_len = 16'd3;
        tick();
        tag_valid = 1'b0; frame_len = LEN_W'($urandom());
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[31:0] !== 32'h7) begin
            bad++;
            $display("FAIL basic_beat0: got tvalid=%b low=%h required tvalid=1 low=00000007", m_axis_tvalid, m_axis_tdata[31:0]);
        end
        wait_beats(HDR_BEATS + 3, 50);
        repeat (3) tick();
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL basic_stream: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
        total++;
        if (done_cnt !== 1 || done_cyc !== tlast_cyc + 1) begin
            bad++; $display("FAIL basic_done: got count=%0d at +%0d required count=1 at +1", done_cnt, done_cyc - tlast_cyc);
        end
        total++;
        if (srdy_cycles !== 3) begin bad++; $display("FAIL basic_s_tready: got %0d cycles required 3", srdy_cycles); end
    endtask

    task automatic test_len0();
        logic [TAG_W-1:0] t;
        int d;
        start_scenario();
        t = make_tag(32'h0000_0011, 8'h5a);
        expect_frame(t, 0);
        tag_valid = 1'b1; tag_info = t; frame_len = 16'd0;
        tick();
        tag_valid = 1'b0; frame_len = LEN_W'($urandom_range(1, 500));
        wait_beats(HDR_BEATS, 50);
        repeat (3) tick();
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL len0_stream: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
        total++;
        if (srdy_cycles !== 0 || done_cnt !== 1) begin
            bad++; $display("FAIL len0_flags: got s_tready=%0d done=%0d required 0 and 1", srdy_cycles, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0] t;
        int d;
        start_scenario();
        rdy_mode = 1; src_rand = 1;
        t = make_tag(32'h0000_0022, 8'h5a);
        expect_frame(t, 5);
        tag_valid = 1'b1; tag_info = t; frame_len = 16'd5;
        tick();
        tag_valid = 1'b0;
        wait_beats(HDR_BEATS + 5, 200);
        repeat (4) tick();
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL bp_stream: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
        total++;
        if (stall_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_viol); end
        rdy_mode = 0; src_rand = 0;
    endtask

    task automatic test_overflow();
        logic [TAG_W-1:0] ta, tb, tc;
        int d;
        start_scenario();
        ta = make_tag(32'd100, 8'h5a);
        tb = make_tag(32'd101, 8'h5a);
        tc = make_tag(32'd102, 8'h5a);
        expect_frame(ta, 4);
        expect_frame(tc, 4);
        frame_len = 16'd4;
        tag_valid = 1'b1;
        tag_info = ta; tick();
        tag_info = tb; tick();
        tag_info = tc; tick();
        tag_valid = 1'b0;
        ovf_exp++;
        total++;
        if (ovf_cnt !== 16'(ovf_exp) || busy !== 1'b1) begin
            bad++; $display("FAIL ovf_count: got ovf=%0d busy=%b required ovf=%0d busy=1", ovf_cnt, busy, ovf_exp);
        end
        wait_beats(2 * (HDR_BEATS + 4), 100);
        repeat (3) tick();
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL ovf_stream: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
        total++;
        if (done_cnt !== 2) begin bad++; $display("FAIL ovf_done: got %0d frames required 2", done_cnt); end
    endtask

    task automatic test_enable_pending();
        logic [TAG_W-1:0] td, te, tf;
        int d;
        start_scenario();
        td = make_tag(32'd200, 8'h5a);
        te = make_tag(32'd201, 8'h5a);
        tf = make_tag(32'd202, 8'h5a);
        expect_frame(td, 2);
        expect_frame(te, 2);
        expect_frame(tf, 2);
        frame_len = 16'd2;
        tag_valid = 1'b1; tag_info = td; tick();
        tag_valid = 1'b0; tick();
        enable = 1'b0; tick();
        tag_valid = 1'b1; tag_info = te; tick();
        tag_valid = 1'b0;
        wait_beats(HDR_BEATS + 2, 50);
        repeat (4) tick();
        total++;
        if (busy !== 1'b0 || obs_q.size() !== HDR_BEATS + 2) begin
            bad++; $display("FAIL en_hold: got busy=%b beats=%0d required busy=0 beats=%0d", busy, obs_q.size(), HDR_BEATS + 2);
        end
        enable = 1'b1; tag_valid = 1'b1; tag_info = tf;
        tick();
        tag_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || ovf_cnt !== 16'(ovf_exp)) begin
            bad++; $display("FAIL en_consume: got busy=%b ovf=%0d required busy=1 ovf=%0d", busy, ovf_cnt, ovf_exp);
        end
        wait_beats(3 * (HDR_BEATS + 2), 100);
        repeat (3) tick();
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL en_stream: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
    endtask

    task automatic test_reset_mid();
        logic [TAG_W-1:0] tg, th;
        int d;
        start_scenario();
        tg = make_tag(32'd300, 8'h5a);
        frame_len = 16'd8;
        tag_valid = 1'b1; tag_info = tg; tick();
        tag_valid = 1'b0;
        repeat (HDR_BEATS + 1) tick();
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got s_tready=%b required 1", s_axis_tready); end
        rst_n = 1'b0;
        #1;
        ovf_exp = 0;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy} !== 4'b0 || ovf_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid: got {tvalid,tlast,s_tready,busy}=%b ovf=%0d required 0000 ovf=0",
                     {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy}, ovf_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_stall = 1'b0;
        tick();
        start_scenario();
        th = make_tag(32'd301, 8'h5a);
        expect_frame(th, 3);
        frame_len = 16'd3;
        tag_valid = 1'b1; tag_info = th; tick();
        tag_valid = 1'b0;
        wait_beats(HDR_BEATS + 3, 50);
        repeat (3) tick();
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL rst_after: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
    endtask

    task automatic test_hdr_check();
        logic [TAG_W-1:0] t;
        start_scenario();
        t = make_tag(32'd400, 8'h00);
        frame_len = 16'd2;
        tag_valid = 1'b1; tag_info = t; tick();
        tag_valid = 1'b0;
`ifdef TAG_HDR_CHECK_EN
        total++;
        if (hdr_err !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL hdr_err_pulse: got err=%b tvalid=%b busy=%b required 1 0 0", hdr_err, m_axis_tvalid, busy);
        end
        tick();
        total++;
        if (hdr_err !== 1'b0) begin bad++; $display("FAIL hdr_err_width: got %b required 0", hdr_err); end
        repeat (4) tick();
        total++;
        if (obs_q.size() !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL hdr_err_drop: got beats=%0d busy=%b required 0 0", obs_q.size(), busy);
        end
`else
        expect_frame(t, 2);
        wait_beats(HDR_BEATS + 2, 50);
        repeat (3) tick();
        total++;
        if (first_diff() >= 0) begin
            bad++; $display("FAIL no_check_stream: got %0d beats required %0d matching beats", obs_q.size(), exp_q.size());
        end
`endif
    endtask

    task automatic test_random();
        logic [TAG_W-1:0] t;
        int len;
        int d;
        start_scenario();
        rdy_mode = 2; src_rand = 1;
        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(0, 6);
            t = make_tag($urandom(), 8'h5a);
            expect_frame(t, len);
            tag_valid = 1'b1; tag_info = t; frame_len = LEN_W'(len);
            tick();
            tag_valid = 1'b0; frame_len = LEN_W'($urandom());
            wait_beats(exp_q.size(), 200);
            repeat (3) tick();
        end
        d = first_diff(); total++;
        if (d >= 0) begin bad++; $display("FAIL rand_stream: beat %0d got %h required %h", d, obs_at(d), exp_at(d)); end
        total++;
        if (done_cnt !== 10 || stall_viol !== 0 || ovf_cnt !== 16'(ovf_exp)) begin
            bad++;
            $display("FAIL rand_flags: got done=%0d stalls=%0d ovf=%0d required 10 0 %0d", done_cnt, stall_viol, ovf_cnt, ovf_exp);
        end
        rdy_mode = 0; src_rand = 0;
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b1;
        tag_valid     = 1'b0;
        tag_info      = '0;
        frame_len     = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_basic();
        test_len0();
        test_backpressure();
        test_overflow();
        test_enable_pending();
        test_reset_mid();
        test_hdr_check();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
